// File: rtl/delay_sched_pkg.sv
// -----------------------------------------------------------------------------
// delay_sched_pkg
//   Shared definitions for the delay scheduler: FSM state encoding and the
//   default sizing constants.
//   Ports: none (package).
//   Optional feature macro used by the scheduler: DELAY_SCHED_CANCEL_EN.
// -----------------------------------------------------------------------------
package delay_sched_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 8;

  // ST_BAD is never entered on purpose; if it is ever seen the FSM recovers
  // to ST_IDLE on the next edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. The search starts at index
//   (last+1) mod NUM_REQ and returns the first requester whose req bit is set.
//   Ports:
//     req   in  NUM_REQ  request vector
//     last  in  IDX_W    index of the previously served requester
//     gnt   out NUM_REQ  one-hot pick (all zero when valid is low)
//     idx   out IDX_W    index of the pick
//     valid out 1        at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    valid   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    // Walk the ring once, starting just after the last winner; the first hit
    // locks the result.
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = int'(last) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!valid && req[pos_idx]) begin
        valid        = 1'b1;
        idx          = pos_idx;
        gnt[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// -----------------------------------------------------------------------------
// delay_scheduler
//   Shares one down-counter among NUM_REQ requesters that each need a one-shot
//   delay. A round-robin arbiter picks a pending requester in IDLE, its delay
//   value is captured, grant is held while the count runs down to zero, and a
//   one-cycle done pulse goes to the owner at expiry. A mandatory DONE cycle
//   separates consecutive owners.
//   Optional feature: define DELAY_SCHED_CANCEL_EN to add the cancel input and
//   the aborted output (abort of the running delay).
//   Ports:
//     clk     in  1              rising-edge clock
//     res_n   in  1              asynchronous active-low reset
//     req     in  NUM_REQ        level request per requester
//     delay   in  NUM_REQ*CNT_W  packed delays, requester i at [i*CNT_W +: CNT_W]
//     grant   out NUM_REQ        one-hot owner of the counter, zero when idle
//     done    out NUM_REQ        one-cycle expiry pulse to the owner
//     busy    out 1              high whenever the FSM is not idle
//     cnt_out out CNT_W          remaining count
//     cancel  in  1              abort running delay (DELAY_SCHED_CANCEL_EN)
//     aborted out 1              one-cycle abort pulse (DELAY_SCHED_CANCEL_EN)
// -----------------------------------------------------------------------------
module delay_scheduler
  import delay_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] delay,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt_out
`ifdef DELAY_SCHED_CANCEL_EN
  ,
  input  logic                     cancel,
  output logic                     aborted
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  logic [CNT_W-1:0]   dly_arr [NUM_REQ];
  logic [CNT_W-1:0]   sel_delay;
  logic               stop;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req),
    .last  (last),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign dly_arr[i] = delay[i*CNT_W +: CNT_W];
  end

  assign sel_delay = dly_arr[arb_idx];

`ifdef DELAY_SCHED_CANCEL_EN
  assign stop = cancel;
`else
  assign stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state   <= ST_IDLE;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      cnt_out <= '0;
      owner   <= '0;
      last    <= IDX_W'(NUM_REQ - 1);
`ifdef DELAY_SCHED_CANCEL_EN
      aborted <= 1'b0;
`endif
    end else begin
      // done and aborted are single-cycle pulses; default them low.
      done <= '0;
`ifdef DELAY_SCHED_CANCEL_EN
      aborted <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            state   <= ST_RUN;
            grant   <= arb_gnt;
            busy    <= 1'b1;
            cnt_out <= sel_delay;
            owner   <= arb_idx;
            last    <= arb_idx;
          end else begin
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Cancel takes priority over expiry; the count freezes where it is.
          if (stop) begin
            state <= ST_DONE;
            grant <= '0;
`ifdef DELAY_SCHED_CANCEL_EN
            aborted <= 1'b1;
`endif
          end else if (cnt_out == '0) begin
            state        <= ST_DONE;
            grant        <= '0;
            done[owner]  <= 1'b1;
          end else begin
            cnt_out <= cnt_out - CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Mandatory gap cycle: requests are not looked at here.
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_scheduler.sv
// -----------------------------------------------------------------------------
// tb_delay_scheduler
//   Directed and randomized stimulus for delay_scheduler, checked every cycle
//   against a transaction-level schedule model: each grant is described by its
//   start edge, captured delay and owner, and all expected outputs are derived
//   from those numbers with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_delay_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           res_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] delay;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   cnt_out;
`ifdef DELAY_SCHED_CANCEL_EN
  logic           cancel;
  logic           aborted;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Schedule model state
  int e;       // index of the most recent rising edge
  int g;       // edge at which the current owner was granted
  int d;       // delay captured at grant
  int own;     // current owner index
  int last;    // last served index
  int ce;      // edge at which cancel took effect, -1 if none
  int m_free;  // first edge at which a new request can be accepted
  bit have;    // a transaction has been issued since reset

  always #5 clk = ~clk;

  delay_scheduler #(
    .NUM_REQ (N),
    .CNT_W   (W)
  ) dut (
    .clk     (clk),
    .res_n   (res_n),
    .req     (req),
    .delay   (delay),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .cnt_out (cnt_out)
`ifdef DELAY_SCHED_CANCEL_EN
    ,
    .cancel  (cancel),
    .aborted (aborted)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, e);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int lst);
    int rv;
    int p;
    rv = int'(r);
    for (int i = 1; i <= N; i++) begin
      p = (lst + i) % N;
      if (((rv >> p) & 1) != 0) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    have   = 1'b0;
    last   = N - 1;
    ce     = -1;
    m_free = e + 1;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once.
  task automatic do_reset();
    res_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(cnt_out), 0);
`ifdef DELAY_SCHED_CANCEL_EN
    chk("rst_aborted", 32'(aborted), 0);
`endif
    res_n = 1'b1;
    model_reset();
  endtask

  // One clock edge: capture the inputs the DUT samples, advance the model,
  // then compare all outputs 1 time unit after the edge.
  task automatic step();
    logic [N-1:0]   r;
    logic [N*W-1:0] dl;
    logic           c;
    int s, endr, fin, expg, expc, expd, expb, expa;
    r  = req;
    dl = delay;
    c  = 1'b0;
`ifdef DELAY_SCHED_CANCEL_EN
    c  = cancel;
`endif
    @(posedge clk);
    e++;
    if (have && ce < 0 && c && e >= g + 1 && e <= g + d + 1) ce = e;
    if (e >= m_free && r != '0) begin
      s    = pick(r, last);
      own  = s;
      last = s;
      g    = e;
      d    = int'(dl[s*W +: W]);
      ce   = -1;
      have = 1'b1;
    end
    if (have) m_free = (ce >= 0) ? ce + 2 : g + d + 3;
    endr = (ce >= 0) ? ce - 1 : g + d;
    fin  = endr + 1;
    expg = (have && e >= g && e <= endr) ? (1 << own) : 0;
    expc = !have ? 0 : ((e <= endr) ? d - (e - g) : d - (endr - g));
    expd = (have && ce < 0 && e == fin) ? (1 << own) : 0;
    expb = (have && e >= g && e <= fin) ? 1 : 0;
    expa = (have && ce >= 0 && e == ce) ? 1 : 0;
    #1;
    chk("grant", 32'(grant), expg);
    chk("cnt_out", 32'(cnt_out), expc);
    chk("done", 32'(done), expd);
    chk("busy", 32'(busy), expb);
`ifdef DELAY_SCHED_CANCEL_EN
    chk("aborted", 32'(aborted), expa);
`else
    if (expa != 0) chk("aborted_model", 32'(expa), 0);
`endif
  endtask

  initial begin
    res_n = 1'b0;
    req   = '0;
    delay = '0;
`ifdef DELAY_SCHED_CANCEL_EN
    cancel = 1'b0;
`endif
    e = 0; g = 0; d = 0; own = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(cnt_out), 0);
    res_n = 1'b1;
    model_reset();

    // Single request: requester 2, delay 5
    delay[2*W +: W] = 8'd5;
    req = 4'b0100;
    step();
    chk("single_grant", 32'(grant), 32'h4);
    req = '0;
    repeat (9) step();

    // Contention from reset: order 0,1,3,0
    do_reset();
    delay = {N{8'd3}};
    req   = 4'b1011;
    repeat (24) step();
    req = '0;
    repeat (8) step();

    // Zero delay: exactly one RUN cycle
    delay[0 +: W] = 8'd0;
    req = 4'b0001;
    step();
    req = '0;
    repeat (4) step();

    // Maximum delay: 256 RUN cycles, no wrap
    delay[W +: W] = 8'hFF;
    req = 4'b0010;
    step();
    req = '0;
    repeat (259) step();

    // Delay rewritten after grant is ignored
    delay[W +: W] = 8'd4;
    req = 4'b0010;
    step();
    delay[W +: W] = 8'd9;
    req = '0;
    repeat (8) step();

    // Reset in the middle of a run, then requester 0 wins first
    delay[3*W +: W] = 8'd10;
    req = 4'b1000;
    step();
    req = '0;
    for (int i = 0; i < 20 && cnt_out !== 8'd3; i++) step();
    chk("wait_cnt3", 32'(cnt_out), 3);
    do_reset();
    delay = {N{8'd2}};
    req   = 4'b1111;
    step();
    chk("post_reset_first", 32'(grant), 32'h1);
    req = '0;
    repeat (6) step();

`ifdef DELAY_SCHED_CANCEL_EN
    // Cancel mid-count: count frozen at 2, no done
    delay[2*W +: W] = 8'd6;
    req = 4'b0100;
    step();
    req = '0;
    for (int i = 0; i < 20 && cnt_out !== 8'd2; i++) step();
    chk("wait_cnt2", 32'(cnt_out), 2);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    repeat (4) step();

    // Cancel coinciding with count zero: cancel wins
    delay[2*W +: W] = 8'd1;
    req = 4'b0100;
    step();
    req = '0;
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    repeat (3) step();
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < N; k++) delay[k*W +: W] = W'($urandom_range(0, 12));
      end
`ifdef DELAY_SCHED_CANCEL_EN
      cancel = ($urandom_range(0, 15) == 0);
`endif
      step();
    end
    req = '0;
`ifdef DELAY_SCHED_CANCEL_EN
    cancel = 1'b0;
`endif
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/delay_scheduler.md
# delay_scheduler

Time-shares one down-counter among NUM_REQ requesters that each need a one-shot delay of a programmable number of cycles. A round-robin arbiter picks one pending requester, captures its delay value, asserts its grant while the count runs, and pulses its done line at expiry. The block sits between protocol engines (timeouts, back-off, settle waits) and the single shared timing resource.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- CNT_W, 8, delay/counter width in bits
- clk  in  1  rising-edge clock
- res_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  level request per requester
- delay  in  NUM_REQ*CNT_W  packed delay values; requester i uses bits [i*CNT_W +: CNT_W]
- grant  out  NUM_REQ  one-hot owner of the counter; all zero when idle
- done  out  NUM_REQ  one-cycle expiry pulse to the owner
- busy  out  1  high whenever state is not IDLE
- cnt_out  out  CNT_W  remaining count
- cancel  in  1  abort current delay (only with DELAY_SCHED_CANCEL_EN)
- aborted  out  1  one-cycle abort pulse (only with DELAY_SCHED_CANCEL_EN)

## Operation
- States: IDLE, RUN, DONE. All outputs registered.
- IDLE, req != 0: arbiter selects index s -> state RUN, grant <= onehot(s), cnt_out <= delay[s], owner <= s, last <= s.
- IDLE, req == 0: hold; grant = 0, cnt_out holds its last value.
- RUN, cnt_out != 0: cnt_out <= cnt_out - 1, modulo 2^CNT_W; no wrap possible since 0 exits.
- RUN, cnt_out == 0: state DONE, grant <= 0, done[owner] <= 1.
- DONE: done cleared next edge; req ignored in this cycle; state IDLE.
- The DONE cycle is a mandatory gap. A requester drops req on the edge after it sees done. A req still high in IDLE counts as a new request.
- Round-robin: the search starts at (last+1) mod NUM_REQ and picks the first set req bit. Reset value of last is NUM_REQ-1, so requester 0 has first priority.
- delay is sampled only at grant. Later changes are ignored.
- A requester dropping req during RUN does not stop the count. Only cancel does.
- delay = 0: exactly one RUN cycle.
- Reset, asynchronous and possible mid-operation: state IDLE, grant 0, done 0, busy 0, cnt_out 0, aborted 0, last NUM_REQ-1.

## Timing
- req sampled high in IDLE at edge k: grant and busy are high from k+1. grant stays high for delay+1 cycles, through edge k+1+delay.
- done is high in the cycle after edge k+2+delay, the same cycle grant falls. busy is still high in that cycle.
- IDLE is reached at edge k+3+delay. The earliest next grant follows at edge k+4+delay.
- Latency from req to done is delay+2 edges. The issue-to-issue period under back-to-back load is delay+3 cycles.
- Simultaneous requests are resolved the same cycle. Losers wait with req held and are served in round-robin order.

## Configuration
- DELAY_SCHED_CANCEL_EN defined:
  - cancel and aborted ports exist.
  - cancel high in RUN: next state DONE, grant <= 0, aborted <= 1, done stays 0, cnt_out is frozen.
  - cancel in IDLE or DONE is ignored.
  - If cancel coincides with cnt_out == 0, cancel wins.
- Undefined: the ports are absent and RUN ends only on count zero.

## Structure
- Package delay_sched_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - default constants for NUM_REQ and CNT_W
  - the 2'd3 encoding, which is illegal and recovers to IDLE
- Sub-module rr_arbiter:
  - purely combinational round-robin pick
  - inputs: req, last; outputs: one-hot gnt, index, valid
  - parameterised by NUM_REQ
  - reused elsewhere in the codebase
- The FSM, counter and registers live in delay_scheduler.

## Test plan
- Single request, NUM_REQ=4, CNT_W=8: req[2]=1, delay[2]=5 at edge 0 -> grant=4'b0100 for edges 1..6, cnt_out 5..0, done[2] pulse in the cycle after edge 7, busy low after edge 8.
- Contention: req=4'b1011 held, delay=3 for all, after reset -> grant order 0,1,3,0, with each grant delay+3=6 cycles after the previous.
- Boundaries:
  - delay[0]=0 -> one RUN cycle, done at edge 2.
  - delay[1]=8'hFF -> 256 RUN cycles, no wrap, done at edge 257.
- Reset mid-RUN: res_n low at cnt_out=3 -> all outputs 0 immediately. After release, req[0] granted first.
- Cancel (macro defined): cancel at cnt_out=2 -> aborted pulse, done stays 0, cnt_out frozen at 2, IDLE 2 edges later. Cancel at cnt_out=0 -> aborted, no done.
- Delay change during RUN: delay[1] rewritten 4->9 after grant -> count still runs 4..0.
